// File: rtl/minesweeper_pkg.sv
// rtl/minesweeper_pkg.sv - shared state, cell encodings and neighbour order for the board controller
package minesweeper_pkg;

   typedef enum logic [2:0] {
      IDLE, PLACE, PLAY, CHECK, COUNT, WRITE, LOSE, WIN
   } state_t;

   localparam logic [3:0]  CELL_HIDDEN  = 4'd9;
   localparam logic [3:0]  CELL_FLAGGED = 4'd10;
   localparam logic [3:0]  CELL_MINE    = 4'd11;
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;

   typedef struct packed {
      logic signed [1:0] dr;
      logic signed [1:0] dc;
   } nb_ofs_t;

   // Neighbour scan order: NW, N, NE, W, E, SW, S, SE
   function automatic nb_ofs_t nb_offset(input logic [2:0] k);
      nb_ofs_t o;
      case (k)
         3'd0:    o = '{-2'sd1, -2'sd1};
         3'd1:    o = '{-2'sd1,  2'sd0};
         3'd2:    o = '{-2'sd1,  2'sd1};
         3'd3:    o = '{ 2'sd0, -2'sd1};
         3'd4:    o = '{ 2'sd0,  2'sd1};
         3'd5:    o = '{ 2'sd1, -2'sd1};
         3'd6:    o = '{ 2'sd1,  2'sd0};
         default: o = '{ 2'sd1,  2'sd1};
      endcase
      return o;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR (taps 16,14,13,11) used for mine placement
module lfsr16
   import minesweeper_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   input  logic        en,
   output logic [15:0] value
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         value <= seed;
      else if (en)
         value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
   end

endmodule

// File: rtl/minesweeper_board_ctrl.sv
// rtl/minesweeper_board_ctrl.sv - minesweeper board: mine placement, cursor, flag/reveal sequencing
module minesweeper_board_ctrl
   import minesweeper_pkg::*;
#(
   parameter int          ROWS  = 8,
   parameter int          COLS  = 8,
   parameter int          MINES = 10,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           up,
   input  logic                           down,
   input  logic                           left,
   input  logic                           right,
   input  logic                           reveal,
   input  logic                           flag,
   input  logic [$clog2(ROWS)-1:0]        rd_row,
   input  logic [$clog2(COLS)-1:0]        rd_col,
   output logic [3:0]                     cell_state,
   output logic [$clog2(ROWS)-1:0]        cur_row,
   output logic [$clog2(COLS)-1:0]        cur_col,
   output logic                           busy,
   output logic                           game_over,
   output logic                           win,
   output logic [$clog2(ROWS*COLS+1)-1:0] revealed_cnt,
   output logic [$clog2(MINES+1)-1:0]     flags_left,
   output logic [ROWS*COLS-1:0]           mine_map
);

   localparam int NCELL = ROWS * COLS;
   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int IW    = $clog2(NCELL);
   localparam int VW    = $clog2(NCELL + 1);
   localparam int FW    = $clog2(MINES + 1);
   localparam int SAFE  = NCELL - MINES;

   state_t           state, nxt;
   logic [NCELL-1:0] mine, revealed, flagged;
   logic [3:0]       cnt [NCELL];
   logic [RW-1:0]    tgt_row;
   logic [CW-1:0]    tgt_col;
   logic [2:0]       nb;
   logic [3:0]       acc;
   logic [FW-1:0]    remaining;
   logic [15:0]      lfsr_val;
   logic             unused_lfsr;
   logic [IW-1:0]    place_idx, cur_idx, tgt_idx, nb_idx, rd_idx;
   logic             place_ok, nb_mine, start_ok;
   nb_ofs_t          nb_ofs;
   int               nb_r, nb_c;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .seed  (SEED),
      .en    (state == PLACE),
      .value (lfsr_val)
   );

   assign unused_lfsr = ^lfsr_val[15:IW];
   assign place_idx   = lfsr_val[IW-1:0];
   assign place_ok    = (int'(place_idx) < NCELL) && !mine[place_idx];
   assign cur_idx     = IW'(int'(cur_row) * COLS + int'(cur_col));
   assign tgt_idx     = IW'(int'(tgt_row) * COLS + int'(tgt_col));
   assign rd_idx      = IW'(int'(rd_row) * COLS + int'(rd_col));
   assign start_ok    = start && (state == IDLE || state == LOSE || state == WIN);
   assign mine_map    = mine;

   // Off-board neighbours still take their COUNT cycle but never contribute.
   always_comb begin
      nb_ofs  = nb_offset(nb);
      nb_r    = int'(tgt_row) + int'(nb_ofs.dr);
      nb_c    = int'(tgt_col) + int'(nb_ofs.dc);
      nb_idx  = IW'(nb_r * COLS + nb_c);
      nb_mine = (nb_r >= 0) && (nb_r < ROWS) && (nb_c >= 0) && (nb_c < COLS) && mine[nb_idx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:  if (start) nxt = PLACE;
         PLACE: if (remaining == '0 || (place_ok && remaining == FW'(1))) nxt = PLAY;
         PLAY:  if (reveal) nxt = CHECK;
         CHECK: begin
            if (flagged[tgt_idx] || revealed[tgt_idx]) nxt = PLAY;
            else if (mine[tgt_idx])                    nxt = LOSE;
            else                                       nxt = COUNT;
         end
         COUNT: if (nb == 3'd7) nxt = WRITE;
         WRITE: nxt = (int'(revealed_cnt) + 1 == SAFE) ? WIN : PLAY;
         LOSE:  if (start) nxt = PLACE;
         WIN:   if (start) nxt = PLACE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == PLACE) || (state == CHECK) || (state == COUNT) || (state == WRITE);
      game_over  = (state == LOSE);
      win        = (state == WIN);
      cell_state = CELL_HIDDEN;
      if ((int'(rd_row) < ROWS) && (int'(rd_col) < COLS)) begin
         if ((state == LOSE || state == WIN) && mine[rd_idx]) cell_state = CELL_MINE;
         else if (revealed[rd_idx])                           cell_state = cnt[rd_idx];
         else if (flagged[rd_idx])                            cell_state = CELL_FLAGGED;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mine         <= '0;
         revealed     <= '0;
         flagged      <= '0;
         for (int i = 0; i < NCELL; i++) cnt[i] <= '0;
         cur_row      <= '0;
         cur_col      <= '0;
         tgt_row      <= '0;
         tgt_col      <= '0;
         nb           <= '0;
         acc          <= '0;
         remaining    <= FW'(MINES);
         revealed_cnt <= '0;
         flags_left   <= FW'(MINES);
      end else begin
         if (start_ok) begin
            mine         <= '0;
            revealed     <= '0;
            flagged      <= '0;
            remaining    <= FW'(MINES);
            revealed_cnt <= '0;
            flags_left   <= FW'(MINES);
         end
         case (state)
            PLACE: begin
               if (remaining != '0 && place_ok) begin
                  mine[place_idx] <= 1'b1;
                  remaining       <= remaining - FW'(1);
               end
            end
            PLAY: begin
               if (reveal) begin
                  tgt_row <= cur_row;
                  tgt_col <= cur_col;
               end else if (flag) begin
                  if (!revealed[cur_idx]) begin
                     if (flagged[cur_idx]) begin
                        flagged[cur_idx] <= 1'b0;
                        flags_left       <= flags_left + FW'(1);
                     end else if (flags_left != '0) begin
                        flagged[cur_idx] <= 1'b1;
                        flags_left       <= flags_left - FW'(1);
                     end
                  end
               end else if (up) begin
                  if (cur_row != '0) cur_row <= cur_row - RW'(1);
               end else if (down) begin
                  if (int'(cur_row) < ROWS - 1) cur_row <= cur_row + RW'(1);
               end else if (left) begin
                  if (cur_col != '0) cur_col <= cur_col - CW'(1);
               end else if (right) begin
                  if (int'(cur_col) < COLS - 1) cur_col <= cur_col + CW'(1);
               end
            end
            CHECK: begin
               nb  <= '0;
               acc <= '0;
            end
            COUNT: begin
               acc <= acc + {3'b000, nb_mine};
               nb  <= nb + 3'd1;
            end
            WRITE: begin
               cnt[tgt_idx]      <= acc;
               revealed[tgt_idx] <= 1'b1;
               revealed_cnt      <= revealed_cnt + VW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_minesweeper_board_ctrl.sv
// tb/tb_minesweeper_board_ctrl.sv - scoreboard bench for minesweeper_board_ctrl
module tb_minesweeper_board_ctrl;

   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int MINES = 10;
   localparam int NCELL = ROWS * COLS;
   localparam int SAFE  = NCELL - MINES;

   logic        clk = 1'b0;
   logic        rst, start, up, down, left, right, reveal, flag;
   logic [2:0]  rd_row, rd_col;
   logic [3:0]  cell_state;
   logic [2:0]  cur_row, cur_col;
   logic        busy, game_over, win;
   logic [6:0]  revealed_cnt;
   logic [3:0]  flags_left;
   logic [63:0] mine_map;

   minesweeper_board_ctrl #(.ROWS(ROWS), .COLS(COLS), .MINES(MINES), .SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .start(start), .up(up), .down(down), .left(left), .right(right),
      .reveal(reveal), .flag(flag), .rd_row(rd_row), .rd_col(rd_col), .cell_state(cell_state),
      .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .game_over(game_over), .win(win),
      .revealed_cnt(revealed_cnt), .flags_left(flags_left), .mine_map(mine_map)
   );

   always #5 clk = ~clk;

   string       tag_q[$];
   logic [31:0] exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] mm;
   int          pos_r = 0;
   int          pos_c = 0;

   task automatic expect_val(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic observe(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // dir: 0 up, 1 down, 2 left, 3 right; one pulse per cycle
   task automatic move(input int dir, input int n);
      for (int i = 0; i < n; i++) begin
         {up, down, left, right} = 4'b1000 >> dir;
         tick();
      end
      {up, down, left, right} = 4'b0000;
   endtask

   task automatic goto(input int r, input int c);
      if (r < pos_r) move(0, pos_r - r);
      else if (r > pos_r) move(1, r - pos_r);
      if (c < pos_c) move(2, pos_c - c);
      else if (c > pos_c) move(3, c - pos_c);
      pos_r = r;
      pos_c = c;
      expect_val("goto_row", r);
      expect_val("goto_col", c);
      observe(cur_row);
      observe(cur_col);
   endtask

   task automatic pulse_flag();
      flag = 1'b1;
      tick();
      flag = 1'b0;
   endtask

   task automatic read_cell(input int r, input int c, output logic [3:0] v);
      rd_row = 3'(r);
      rd_col = 3'(c);
      #1;
      v = cell_state;
   endtask

   task automatic reveal_wait(output int lat);
      reveal = 1'b1;
      tick();
      reveal = 1'b0;
      lat = 0;
      while (busy === 1'b1 && lat < 40) begin
         lat++;
         tick();
      end
   endtask

   function automatic int ref_count(input logic [63:0] m, input int r, input int c);
      int n = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < ROWS && c + dc >= 0 && c + dc < COLS)
               n += int'(m[(r + dr) * COLS + c + dc]);
      return n;
   endfunction

   task automatic wait_place();
      int n = 0;
      while (busy === 1'b1 && n < 5000) begin
         tick();
         n++;
      end
      mm = mine_map;
      expect_val("place_done", 1);       observe(busy === 1'b0);
      expect_val("place_len_min", 1);    observe(n >= MINES);
      expect_val("mine_popcount", MINES); observe($countones(mine_map));
      expect_val("flags_left_new", MINES); observe(flags_left);
      expect_val("revealed_new", 0);     observe(revealed_cnt);
   endtask

   task automatic check_reset_values();
      expect_val("rst_busy", 0);       observe(busy);
      expect_val("rst_game_over", 0);  observe(game_over);
      expect_val("rst_win", 0);        observe(win);
      expect_val("rst_revealed", 0);   observe(revealed_cnt);
      expect_val("rst_flags_left", MINES); observe(flags_left);
      expect_val("rst_cur_row", 0);    observe(cur_row);
      expect_val("rst_cur_col", 0);    observe(cur_col);
      expect_val("rst_mine_map", 1);   observe(mine_map === 64'd0);
      expect_val("rst_cell_state", 9); observe(cell_state);
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] v;
      int lat, sr, sc, fr, fc, mr, mc, bad, k;
      int fl_r[11];
      int fl_c[11];

      rst = 1'b0; start = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
      reveal = 1'b0; flag = 1'b0; rd_row = '0; rd_col = '0;
      repeat (3) tick();
      check_reset_values();
      rst = 1'b1;
      tick();
      expect_val("idle_busy", 0); observe(busy);

      // new game: placement
      start = 1'b1;
      expect_val("place_busy", 1);
      tick();
      start = 1'b0;
      observe(busy);
      wait_place();
      bad = 0;
      for (int i = 0; i < NCELL; i++) begin
         read_cell(i / COLS, i % COLS, v);
         if (v !== 4'd9) bad++;
      end
      expect_val("all_hidden", 0); observe(bad);

      // cursor saturation and movement
      move(2, 10);
      move(0, 10);
      expect_val("sat_row0", 0); observe(cur_row);
      expect_val("sat_col0", 0); observe(cur_col);
      move(1, 9);
      expect_val("sat_row7", 7); observe(cur_row);
      move(3, 2);
      expect_val("right2_col", 2); observe(cur_col);
      move(2, 1);
      expect_val("left1_col", 1); observe(cur_col);
      pos_r = 7; pos_c = 1;

      // reveal of a safe cell, with a simultaneous down that must be dropped
      sr = -1; sc = 0;
      for (int i = 0; i < NCELL; i++)
         if (sr < 0 && !mm[i] && i / COLS < ROWS - 1 && ref_count(mm, i / COLS, i % COLS) > 0) begin
            sr = i / COLS; sc = i % COLS;
         end
      for (int i = 0; i < NCELL; i++)
         if (sr < 0 && !mm[i] && i / COLS < ROWS - 1) begin
            sr = i / COLS; sc = i % COLS;
         end
      goto(sr, sc);
      rd_row = 3'(sr);
      rd_col = 3'(sc);
      reveal = 1'b1;
      down = 1'b1;
      for (int i = 0; i < 10; i++) expect_val("reveal_busy", 1);
      tick();
      reveal = 1'b0;
      down = 1'b0;
      for (int i = 0; i < 10; i++) begin
         observe(busy);
         if (i == 9) begin
            expect_val("hidden_during_write", 9);
            observe(cell_state);
         end
         tick();
      end
      expect_val("reveal_done", 0);               observe(busy);
      expect_val("reveal_count", ref_count(mm, sr, sc)); observe(cell_state);
      expect_val("reveal_cnt1", 1);               observe(revealed_cnt);
      expect_val("reveal_down_dropped", sr);      observe(cur_row);
      reveal_wait(lat);
      expect_val("rereveal_lat", 1);              observe(lat);
      expect_val("rereveal_cnt", 1);              observe(revealed_cnt);
      expect_val("rereveal_state", ref_count(mm, sr, sc)); observe(cell_state);

      // flags
      fr = -1; fc = 0;
      for (int i = 0; i < NCELL; i++)
         if (fr < 0 && !mm[i] && !(i / COLS == sr && i % COLS == sc)) begin
            fr = i / COLS; fc = i % COLS;
         end
      goto(fr, fc);
      rd_row = 3'(fr);
      rd_col = 3'(fc);
      expect_val("flag_set_state", 10);
      expect_val("flag_set_left", MINES - 1);
      pulse_flag();
      observe(cell_state);
      observe(flags_left);
      reveal_wait(lat);
      expect_val("flagged_reveal_lat", 1);   observe(lat);
      expect_val("flagged_reveal_state", 10); observe(cell_state);
      expect_val("flagged_reveal_cnt", 1);   observe(revealed_cnt);
      expect_val("flag_clr_state", 9);
      expect_val("flag_clr_left", MINES);
      pulse_flag();
      observe(cell_state);
      observe(flags_left);
      goto(sr, sc);
      rd_row = 3'(sr);
      rd_col = 3'(sc);
      pulse_flag();
      expect_val("flag_revealed_left", MINES); observe(flags_left);
      expect_val("flag_revealed_state", ref_count(mm, sr, sc)); observe(cell_state);

      k = 0;
      for (int i = 0; i < NCELL; i++)
         if (k < 11 && !mm[i] && !(i / COLS == sr && i % COLS == sc)) begin
            fl_r[k] = i / COLS; fl_c[k] = i % COLS; k++;
         end
      for (int j = 0; j < 11; j++) begin
         goto(fl_r[j], fl_c[j]);
         pulse_flag();
      end
      expect_val("flags_exhausted", 0); observe(flags_left);
      read_cell(fl_r[9], fl_c[9], v);
      expect_val("tenth_flagged", 10); observe(v);
      read_cell(fl_r[10], fl_c[10], v);
      expect_val("eleventh_ignored", 9); observe(v);
      tick();

      // lose on a mine
      mr = -1; mc = 0;
      for (int i = 0; i < NCELL; i++)
         if (mr < 0 && mm[i]) begin
            mr = i / COLS; mc = i % COLS;
         end
      goto(mr, mc);
      rd_row = 3'(mr);
      rd_col = 3'(mc);
      reveal = 1'b1;
      expect_val("mine_check_busy", 1);
      expect_val("mine_check_go", 0);
      tick();
      reveal = 1'b0;
      observe(busy);
      observe(game_over);
      tick();
      expect_val("lose_game_over", 1); observe(game_over);
      expect_val("lose_busy", 0);      observe(busy);
      expect_val("lose_mine_state", 11); observe(cell_state);
      bad = 0;
      for (int i = 0; i < NCELL; i++)
         if (mm[i]) begin
            read_cell(i / COLS, i % COLS, v);
            if (v !== 4'd11) bad++;
         end
      expect_val("lose_all_mines_shown", 0); observe(bad);
      read_cell(fl_r[0], fl_c[0], v);
      expect_val("lose_flag_state", 10); observe(v);
      tick();
      reveal = 1'b1; flag = 1'b1; up = 1'b1; right = 1'b1;
      repeat (3) tick();
      reveal = 1'b0; flag = 1'b0; up = 1'b0; right = 1'b0;
      expect_val("lose_hold", 1);      observe(game_over);
      expect_val("lose_row", mr);      observe(cur_row);
      expect_val("lose_col", mc);      observe(cur_col);
      expect_val("lose_flags", 0);     observe(flags_left);
      expect_val("lose_revealed", 1);  observe(revealed_cnt);
      start = 1'b1;
      expect_val("restart_busy", 1);
      expect_val("restart_go_clr", 0);
      tick();
      start = 1'b0;
      observe(busy);
      observe(game_over);
      wait_place();

      // reveal every safe cell to win
      k = 0;
      for (int i = 0; i < NCELL; i++) begin
         if (!mm[i]) begin
            if (k == SAFE - 1) begin
               expect_val("prewin_win", 0);          observe(win);
               expect_val("prewin_cnt", SAFE - 1);  observe(revealed_cnt);
            end
            goto(i / COLS, i % COLS);
            rd_row = 3'(i / COLS);
            rd_col = 3'(i % COLS);
            reveal_wait(lat);
            k++;
            expect_val("win_rev_lat", 10); observe(lat);
            expect_val("win_rev_count", ref_count(mm, i / COLS, i % COLS)); observe(cell_state);
         end
      end
      expect_val("win_flag", 1);       observe(win);
      expect_val("win_cnt", SAFE);     observe(revealed_cnt);
      expect_val("win_busy", 0);       observe(busy);
      expect_val("win_go", 0);         observe(game_over);
      bad = 0;
      for (int i = 0; i < NCELL; i++)
         if (mm[i]) begin
            read_cell(i / COLS, i % COLS, v);
            if (v !== 4'd11) bad++;
         end
      expect_val("win_all_mines_shown", 0); observe(bad);
      tick();

      // reset in the middle of COUNT
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_place();
      sr = -1; sc = 0;
      for (int i = 0; i < NCELL; i++)
         if (sr < 0 && !mm[i]) begin
            sr = i / COLS; sc = i % COLS;
         end
      goto(sr, sc);
      rd_row = 3'(sr);
      rd_col = 3'(sc);
      reveal = 1'b1;
      tick();
      reveal = 1'b0;
      tick();
      tick();
      expect_val("count_busy", 1); observe(busy);
      rst = 1'b0;
      tick();
      pos_r = 0; pos_c = 0;
      check_reset_values();
      rst = 1'b1;
      tick();
      expect_val("post_rst_idle", 0); observe(busy);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
